wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback-port controller sitting directly upstream of the 32-entry register file built from reg_32 instances.
- Merges single-cycle ALU results and multi-cycle mult/div results onto the register file's single write port.
- Drives the one-hot per-register write enables and the shared write data.
- Keeps a pending-destination scoreboard and raises a decode stall on hazards against in-flight mult/div results.

Parameters:
- NREG, 32, number of architectural registers; must be a power of two.
- AW, 5, register address width, equal to log2(NREG).
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result valid this cycle; cannot be back-pressured.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- md_issue  in  1  mult/div op dispatched this cycle.
- md_issue_rd  in  AW  destination of the dispatched mult/div op.
- md_valid  in  1  mult/div result valid.
- md_rd  in  AW  mult/div result destination.
- md_data  in  DW  mult/div result.
- md_ready  out  1  arbiter can accept a mult/div result.
- md_busy  out  1  a mult/div result is outstanding.
- dec_rs_a  in  AW  decode source A address.
- dec_rs_b  in  AW  decode source B address.
- dec_rd  in  AW  decode destination address.
- dec_rd_we  in  1  decode instruction writes dec_rd.
- stall  out  1  decode must hold this cycle.
- wr_en  out  NREG  one-hot write enable, bit i drives in_enable of register i.
- wr_data  out  DW  write data, common to all registers.

Behaviour:
- Reset (clr_n low, asynchronous):
  - wr_en = 0, wr_data = 0.
  - Scoreboard cleared, hold buffer empty, md_busy = 0.
  - md_ready = 1 as soon as reset is applied.
- Write-slot source selection, evaluated each cycle, priority ALU > hold buffer > direct mult/div:
  - An ALU slot is "real" only if alu_valid and alu_rd != 0.
  - A mult/div result is accepted when md_valid && md_ready.
  - If accepted in the same cycle as a real ALU slot, the result is captured into a 1-entry hold buffer (rd + data).
  - The hold buffer drains in the first cycle with no real ALU slot.
  - md_ready = !hold_valid (registered state, no combinational path from md_valid).
- Output latency:
  - wr_en and wr_data are registered; the selected source appears on the next clock edge.
  - The register updates on the edge after that.
  - Exactly 0 or 1 bit of wr_en is set in any cycle.
- Register 0 is hardwired:
  - Writes to rd 0 from any source are dropped; wr_en[0] is never asserted.
  - A dropped mult/div result to rd 0 still counts as accepted and clears md_busy.
- Scoreboard: pending[NREG-1:0].
  - md_issue with md_issue_rd != 0 sets pending[md_issue_rd].
  - A pending bit clears when its result is placed in wr_en/wr_data, i.e. on the registered write stage, not at acceptance into hold.
  - md_busy = OR of pending, OR hold_valid, OR an outstanding issue to rd 0. A single-bit flag tracks the outstanding rd-0 op and clears on its acceptance.
  - md_issue while md_busy is ignored; at most one mult/div op is in flight.
  - Same-cycle set and clear of the same bit: clear of the old op applies first, then set.
- Stall (combinational):
  - Asserted if pending[dec_rs_a], pending[dec_rs_b], or (dec_rd_we && pending[dec_rd]) for a nonzero address; this covers RAW and WAW hazards.
  - Also asserted if a nonzero dec_rs_a/dec_rs_b matches the rd currently in the registered write stage, since no bypass exists.
  - Address 0 never stalls.
- Reset mid-operation discards the hold buffer and the scoreboard. The mult/div unit is reset by the same clr_n.

Decomposition:
- Shared package: AW, DW, NREG, plus a REG_ZERO constant.
- One natural sub-module: decoder_onehot (AW to NREG one-hot with enable), reused by the scoreboard set/clear logic and the wr_en generation.

Test Plan:
- Reset: hold clr_n low for 3 cycles mid-traffic -> wr_en = 0, md_ready = 1, md_busy = 0, stall = 0 immediately and while low.
- ALU write: alu_valid, rd = 5, data = 0xDEADBEEF -> next cycle wr_en = 0x00000020, wr_data = 0xDEADBEEF for exactly 1 cycle.
- Collision: md_valid rd = 7, data = 0x12345678 together with ALU rd = 3, data = 0x1; then idle ->
  - ALU write (wr_en bit 3) on cycle 1, mult/div write (wr_en bit 7) on cycle 2.
  - md_ready low for exactly 1 cycle.
- Scoreboard hazard: md_issue rd = 9; decode presents dec_rs_b = 9 ->
  - stall held high until the rd-9 write-stage cycle, plus 1 further cycle for the write-stage match.
  - md_busy falls after the write.
- Register 0: ALU rd = 0 and md result rd = 0 -> wr_en stays 0, no stall on dec_rs_a = 0, md_busy clears.
- Issue while busy: second md_issue rd = 4 while rd = 9 pending -> pending[4] stays 0 and stall is not raised for rs = 4.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and types for the writeback arbiter
//
// Purpose:
//   Register-file geometry and the write-slot source encoding used by
//   wb_arbiter and its one-hot decoder.
//
// Contents:
//   NREG      number of architectural registers (power of two)
//   AW        register address width, log2(NREG)
//   DW        data width
//   REG_ZERO  address of the hardwired zero register
//   wb_src_e  which source owns the write slot this cycle

package wb_arbiter_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_HOLD = 2'd2,
    SRC_MD   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter_decoder_onehot.sv
// rtl/wb_arbiter_decoder_onehot.sv - binary address to one-hot vector with enable
//
// Purpose:
//   Turns a register address into a one-hot vector. Used for the write
//   enables and for the scoreboard set/clear masks.
//
// Ports:
//   addr    in   AW    register address
//   en      in   1     when low the output is all zeros
//   onehot  out  NREG  bit addr set when en is high

module wb_arbiter_decoder_onehot #(
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback-port arbiter with pending-destination scoreboard
//
// Purpose:
//   Merges single-cycle ALU results and multi-cycle mult/div results onto the
//   single write port of the register file, and stalls decode on hazards
//   against an in-flight mult/div destination.
//
// Ports:
//   clk          in   1     rising-edge clock
//   clr_n        in   1     asynchronous active-low reset
//   alu_valid    in   1     ALU result valid (never back-pressured)
//   alu_rd       in   AW    ALU destination
//   alu_data     in   DW    ALU result
//   md_issue     in   1     mult/div op dispatched
//   md_issue_rd  in   AW    destination of the dispatched op
//   md_valid     in   1     mult/div result valid
//   md_rd        in   AW    mult/div result destination
//   md_data      in   DW    mult/div result
//   md_ready     out  1     arbiter can accept a mult/div result
//   md_busy      out  1     a mult/div result is outstanding
//   dec_rs_a     in   AW    decode source A
//   dec_rs_b     in   AW    decode source B
//   dec_rd       in   AW    decode destination
//   dec_rd_we    in   1     decode instruction writes dec_rd
//   stall        out  1     decode must hold this cycle
//   wr_en        out  NREG  one-hot register write enable (registered)
//   wr_data      out  DW    write data shared by all registers (registered)

module wb_arbiter #(
  parameter int NREG = wb_arbiter_pkg::NREG,
  parameter int AW   = wb_arbiter_pkg::AW,
  parameter int DW   = wb_arbiter_pkg::DW
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_data,
  input  logic            md_issue,
  input  logic [AW-1:0]   md_issue_rd,
  input  logic            md_valid,
  input  logic [AW-1:0]   md_rd,
  input  logic [DW-1:0]   md_data,
  output logic            md_ready,
  output logic            md_busy,
  input  logic [AW-1:0]   dec_rs_a,
  input  logic [AW-1:0]   dec_rs_b,
  input  logic [AW-1:0]   dec_rd,
  input  logic            dec_rd_we,
  output logic            stall,
  output logic [NREG-1:0] wr_en,
  output logic [DW-1:0]   wr_data
);

  import wb_arbiter_pkg::*;

  localparam logic [AW-1:0] RD_ZERO = AW'(REG_ZERO);

  // Hold buffer: parks a mult/div result that lost the slot to the ALU.
  logic            hold_valid;
  logic [AW-1:0]   hold_rd;
  logic [DW-1:0]   hold_data;

  // Scoreboard of destinations owed by the mult/div unit.
  logic [NREG-1:0] pending;
  // An op issued to rd 0 has no pending bit but still occupies the unit.
  logic            zero_pend;

  // Registered write stage.
  logic [NREG-1:0] wr_en_q;
  logic [DW-1:0]   wr_data_q;
  logic [AW-1:0]   wr_rd_q;

  // Slot selection.
  wb_src_e         src;
  logic [AW-1:0]   slot_rd;
  logic [DW-1:0]   slot_data;
  logic            slot_we;
  logic            slot_md;
  logic            alu_real;
  logic            md_acc;
  logic            hold_load;
  logic            issue_ok;
  logic            zero_issue;
  logic            zero_done;

  logic [NREG-1:0] wr_en_d;
  logic [NREG-1:0] pend_set;
  logic [NREG-1:0] pend_clr;
  logic            wr_stage_busy;
  logic            hit_a;
  logic            hit_b;
  logic            hit_d;

  // Ready depends on registered state only, so there is no path from
  // md_valid back to md_ready.
  assign md_ready = !hold_valid;
  assign md_busy  = (|pending) | hold_valid | zero_pend;

  assign alu_real = alu_valid && (alu_rd != RD_ZERO);
  assign md_acc   = md_valid && md_ready;

  // A second op is only dispatched once the unit has fully drained.
  assign issue_ok   = md_issue && !md_busy && (md_issue_rd != RD_ZERO);
  assign zero_issue = md_issue && !md_busy && (md_issue_rd == RD_ZERO);
  assign zero_done  = md_acc && (md_rd == RD_ZERO);

  // Priority: ALU, then the hold buffer, then a direct mult/div result.
  // While the hold buffer is full md_ready is low, so md_acc cannot fire
  // in the cycle the buffer drains.
  always_comb begin
    src       = SRC_NONE;
    slot_rd   = RD_ZERO;
    slot_data = '0;
    if (alu_real) begin
      src       = SRC_ALU;
      slot_rd   = alu_rd;
      slot_data = alu_data;
    end else if (hold_valid) begin
      src       = SRC_HOLD;
      slot_rd   = hold_rd;
      slot_data = hold_data;
    end else if (md_acc && (md_rd != RD_ZERO)) begin
      src       = SRC_MD;
      slot_rd   = md_rd;
      slot_data = md_data;
    end
  end

  assign slot_we = (src != SRC_NONE);
  assign slot_md = (src == SRC_HOLD) || (src == SRC_MD);

  // Results to rd 0 are dropped at acceptance; they never enter the buffer.
  assign hold_load = md_acc && alu_real && (md_rd != RD_ZERO);

  wb_arbiter_decoder_onehot #(.AW(AW), .NREG(NREG)) u_wr_dec (
    .addr   (slot_rd),
    .en     (slot_we),
    .onehot (wr_en_d)
  );

  // The pending bit clears when the result enters the write stage, not when
  // it is parked in the hold buffer.
  wb_arbiter_decoder_onehot #(.AW(AW), .NREG(NREG)) u_clr_dec (
    .addr   (slot_rd),
    .en     (slot_md),
    .onehot (pend_clr)
  );

  wb_arbiter_decoder_onehot #(.AW(AW), .NREG(NREG)) u_set_dec (
    .addr   (md_issue_rd),
    .en     (issue_ok),
    .onehot (pend_set)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_en_q   <= '0;
      wr_data_q <= '0;
      wr_rd_q   <= RD_ZERO;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_data_q <= slot_we ? slot_data : '0;
      wr_rd_q   <= slot_rd;
    end
  end

  // Clear of the retiring op is applied before the set of a new one.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pending   <= '0;
      zero_pend <= 1'b0;
    end else begin
      pending   <= (pending & ~pend_clr) | pend_set;
      zero_pend <= (zero_pend & ~zero_done) | zero_issue;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hold_valid <= 1'b0;
      hold_rd    <= RD_ZERO;
      hold_data  <= '0;
    end else if (hold_load) begin
      hold_valid <= 1'b1;
      hold_rd    <= md_rd;
      hold_data  <= md_data;
    end else if (src == SRC_HOLD) begin
      hold_valid <= 1'b0;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;

  // No bypass from the write stage, so a source matching the register
  // being written this cycle must wait one more cycle.
  assign wr_stage_busy = |wr_en_q;

  assign hit_a = (dec_rs_a != RD_ZERO) &&
                 (pending[dec_rs_a] || (wr_stage_busy && (wr_rd_q == dec_rs_a)));
  assign hit_b = (dec_rs_b != RD_ZERO) &&
                 (pending[dec_rs_b] || (wr_stage_busy && (wr_rd_q == dec_rs_b)));
  assign hit_d = dec_rd_we && (dec_rd != RD_ZERO) && pending[dec_rd];

  assign stall = hit_a || hit_b || hit_d;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter

module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        md_busy;
  logic [4:0]  dec_rs_a;
  logic [4:0]  dec_rs_b;
  logic [4:0]  dec_rd;
  logic        dec_rd_we;
  logic        stall;
  logic [31:0] wr_en;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .md_issue    (md_issue),
    .md_issue_rd (md_issue_rd),
    .md_valid    (md_valid),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .md_ready    (md_ready),
    .md_busy     (md_busy),
    .dec_rs_a    (dec_rs_a),
    .dec_rs_b    (dec_rs_b),
    .dec_rd      (dec_rd),
    .dec_rd_we   (dec_rd_we),
    .stall       (stall),
    .wr_en       (wr_en),
    .wr_data     (wr_data)
  );

  typedef struct {
    logic [31:0] en;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] exp_en;
  } alu_vec_t;

  typedef struct {
    logic [4:0] rs_a;
    logic [4:0] rs_b;
    logic [4:0] rd;
    logic       rd_we;
    logic       exp_stall;
  } stall_vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  alu_vec_t   alu_tab[5];
  stall_vec_t stall_tab[7];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Every visible write must match the oldest expected write.
  always @(negedge clk) begin
    if (clr_n && (wr_en != 32'h0)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected actual en=%h data=%h required no write", wr_en, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ((wr_en !== mon_e.en) || (wr_data !== mon_e.data)) begin
          n_fail++;
          $display("FAIL wr_scoreboard actual en=%h data=%h required en=%h data=%h",
                   wr_en, wr_data, mon_e.en, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] en, input logic [31:0] data);
    exp_t e;
    e.en   = en;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    md_issue    = 1'b0;
    md_issue_rd = '0;
    md_valid    = 1'b0;
    md_rd       = '0;
    md_data     = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wr_en"},    wr_en,    32'h0);
    check({tag, "_wr_data"},  wr_data,  32'h0);
    check({tag, "_md_ready"}, {31'h0, md_ready}, 32'h1);
    check({tag, "_md_busy"},  {31'h0, md_busy},  32'h0);
    check({tag, "_stall"},    {31'h0, stall},    32'h0);
  endtask

  initial begin
    alu_tab[0] = '{5'd5,  32'hDEADBEEF, 32'h0000_0020};
    alu_tab[1] = '{5'd0,  32'hCAFEF00D, 32'h0000_0000};
    alu_tab[2] = '{5'd31, 32'hA5A5A5A5, 32'h8000_0000};
    alu_tab[3] = '{5'd1,  32'h0000_0001, 32'h0000_0002};
    alu_tab[4] = '{5'd16, 32'h1357_9BDF, 32'h0001_0000};

    // Evaluated with rd 9 pending and rd 4 not pending.
    stall_tab[0] = '{5'd9,  5'd0,  5'd0,  1'b0, 1'b1};
    stall_tab[1] = '{5'd0,  5'd9,  5'd0,  1'b0, 1'b1};
    stall_tab[2] = '{5'd4,  5'd4,  5'd4,  1'b1, 1'b0};
    stall_tab[3] = '{5'd0,  5'd0,  5'd9,  1'b1, 1'b1};
    stall_tab[4] = '{5'd0,  5'd0,  5'd9,  1'b0, 1'b0};
    stall_tab[5] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0};
    stall_tab[6] = '{5'd10, 5'd8,  5'd10, 1'b1, 1'b0};

    clr_n     = 1'b0;
    drive_idle();
    dec_rs_a  = '0;
    dec_rs_b  = '0;
    dec_rd    = '0;
    dec_rd_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    clr_n = 1'b1;
    tick();

    // ALU writes, back to back.
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1;
      alu_rd    = alu_tab[i].rd;
      alu_data  = alu_tab[i].data;
      if (alu_tab[i].exp_en != 32'h0) push_exp(alu_tab[i].exp_en, alu_tab[i].data);
      tick();
      check($sformatf("alu_vec%0d_wr_en", i), wr_en, alu_tab[i].exp_en);
    end
    drive_idle();
    tick();
    check("alu_one_cycle", wr_en, 32'h0);
    tick();
    check("alu_drain", exp_q.size(), 32'd0);

    // ALU and mult/div collide; mult/div goes through the hold buffer.
    md_issue    = 1'b1;
    md_issue_rd = 5'd7;
    tick();
    drive_idle();
    check("coll_busy", {31'h0, md_busy}, 32'h1);
    check("coll_ready_pre", {31'h0, md_ready}, 32'h1);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0001;
    md_valid  = 1'b1; md_rd  = 5'd7; md_data  = 32'h1234_5678;
    push_exp(32'h0000_0008, 32'h0000_0001);
    push_exp(32'h0000_0080, 32'h1234_5678);
    tick();
    drive_idle();
    check("coll_slot1", wr_en, 32'h0000_0008);
    check("coll_ready_low", {31'h0, md_ready}, 32'h0);
    tick();
    check("coll_slot2", wr_en, 32'h0000_0080);
    check("coll_ready_back", {31'h0, md_ready}, 32'h1);
    check("coll_busy_clear", {31'h0, md_busy}, 32'h0);
    tick();

    // Scoreboard hazard on rd 9; second issue to rd 4 while busy is ignored.
    md_issue    = 1'b1;
    md_issue_rd = 5'd9;
    tick();
    md_issue_rd = 5'd4;
    dec_rs_b    = 5'd9;
    #1;
    check("haz_rsb", {31'h0, stall}, 32'h1);
    check("haz_busy", {31'h0, md_busy}, 32'h1);
    tick();
    md_issue = 1'b0;
    dec_rs_b = '0;
    for (int i = 0; i < 7; i++) begin
      dec_rs_a  = stall_tab[i].rs_a;
      dec_rs_b  = stall_tab[i].rs_b;
      dec_rd    = stall_tab[i].rd;
      dec_rd_we = stall_tab[i].rd_we;
      #1;
      check($sformatf("stall_vec%0d", i), {31'h0, stall}, {31'h0, stall_tab[i].exp_stall});
    end
    dec_rs_a  = '0;
    dec_rd    = '0;
    dec_rd_we = 1'b0;
    dec_rs_b  = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("haz_hold", {31'h0, stall}, 32'h1);
    end
    md_valid = 1'b1;
    md_rd    = 5'd9;
    md_data  = 32'h0BAD_F00D;
    push_exp(32'h0000_0200, 32'h0BAD_F00D);
    #1;
    check("haz_pre_write", {31'h0, stall}, 32'h1);
    tick();
    md_valid = 1'b0;
    #1;
    check("haz_wstage_en", wr_en, 32'h0000_0200);
    check("haz_wstage_stall", {31'h0, stall}, 32'h1);
    check("haz_busy_fall", {31'h0, md_busy}, 32'h0);
    tick();
    check("haz_release", {31'h0, stall}, 32'h0);
    dec_rs_a = 5'd4;
    dec_rs_b = '0;
    #1;
    check("busy_issue_rs4", {31'h0, stall}, 32'h0);
    dec_rs_a = '0;

    // Register 0 from both sources.
    alu_valid   = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    md_issue    = 1'b1; md_issue_rd = 5'd0;
    tick();
    drive_idle();
    check("r0_alu_wr_en", wr_en, 32'h0);
    check("r0_busy", {31'h0, md_busy}, 32'h1);
    check("r0_no_stall", {31'h0, stall}, 32'h0);
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h0000_0077;
    tick();
    drive_idle();
    check("r0_md_wr_en", wr_en, 32'h0);
    check("r0_busy_clear", {31'h0, md_busy}, 32'h0);
    check("r0_ready", {31'h0, md_ready}, 32'h1);
    tick();
    check("r0_late_wr_en", wr_en, 32'h0);

    // Reset in the middle of a collision: write stage and hold are full.
    md_issue    = 1'b1;
    md_issue_rd = 5'd12;
    tick();
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd6;  alu_data = 32'h0000_0066;
    md_valid  = 1'b1; md_rd  = 5'd12; md_data  = 32'h0000_1212;
    tick();
    drive_idle();
    dec_rs_a = 5'd12;
    #1;
    clr_n = 1'b0;
    #1;
    check_reset_state("rst_now");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_state("rst_low");
    end
    clr_n = 1'b1;
    tick();
    tick();
    check("rst_after_stall", {31'h0, stall}, 32'h0);
    check("rst_after_busy", {31'h0, md_busy}, 32'h0);
    dec_rs_a = '0;
    tick();

    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
